// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a programmable bubble payload held whenever the stage is empty.
module pipe_skid_stage #(
  parameter int              DW     = 64,
  parameter logic [DW-1:0]   BUBBLE = '0,
  parameter bit              SKID   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] m_q, m_d;
  logic [DW-1:0] s_q, s_d;
  logic          in_fire;
  logic          out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_q;
  assign count     = (state_q == TWO) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);

  // With the skid entry, in_ready depends on state only; without it, it looks through to out_ready.
  assign in_ready  = SKID ? (state_q != TWO) : (~out_valid | out_ready);

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = BUBBLE;
      s_d     = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            m_d     = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_data;
          end else if (in_fire && SKID) begin
            state_d = TWO;
            s_d     = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            m_d     = BUBBLE;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            m_d     = s_q;
            s_d     = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: one skid build and one single-entry build,
// directed stimulus pushes expected payloads, a monitor pops them on every out_fire.
module tb_pipe_skid_stage;

  localparam int          DW  = 16;
  localparam logic [15:0] BUB = 16'hBEEF;

  logic        clk;
  logic        rst;
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_count;
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          tests;
  int          fails;
  bit          done;

  pipe_skid_stage #(.DW(DW), .BUBBLE(BUB), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_skid_stage #(.DW(DW), .BUBBLE(BUB), .SKID(1'b0)) u_single (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; done = 1'b0;
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 16'h0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0; b_out_ready = 1'b0;
    fork
      begin
        #2;
        check_output("rst_a_out_valid", {31'b0, a_out_valid}, 32'd0);
        check_output("rst_a_count", {30'b0, a_count}, 32'd0);
        check_output("rst_a_in_ready", {31'b0, a_in_ready}, 32'd1);
        check_output("rst_a_out_data", {16'b0, a_out_data}, {16'b0, BUB});
        check_output("rst_b_out_data", {16'b0, b_out_data}, {16'b0, BUB});
        step(); step();
        rst = 1'b0;

        // Streaming at full rate
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
          a_in_valid = 1'b1;
          a_in_data  = 16'(i);
          qa.push_back(16'(i));
          check_output("t1_in_ready", {31'b0, a_in_ready}, 32'd1);
          step();
          check_output("t1_count", {30'b0, a_count}, 32'd1);
        end
        a_in_valid = 1'b0;
        step();
        check_output("t1_drain_valid", {31'b0, a_out_valid}, 32'd0);
        check_output("t1_drain_data", {16'b0, a_out_data}, {16'b0, BUB});

        // Backpressure fills both entries and refuses a third
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 16'h000A; qa.push_back(16'h000A);
        step();
        a_in_data = 16'h000B; qa.push_back(16'h000B);
        step();
        a_in_data = 16'h0077;
        for (int i = 0; i < 5; i++) begin
          check_output("t2_count", {30'b0, a_count}, 32'd2);
          check_output("t2_in_ready", {31'b0, a_in_ready}, 32'd0);
          check_output("t2_out_data", {16'b0, a_out_data}, 32'h000A);
          check_output("t2_out_valid", {31'b0, a_out_valid}, 32'd1);
          step();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step(); step();
        check_output("t2_end_valid", {31'b0, a_out_valid}, 32'd0);
        check_output("t2_end_data", {16'b0, a_out_data}, {16'b0, BUB});

        // Flush while full, with a coincident incoming payload that must vanish
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 16'h0031; qa.push_back(16'h0031);
        step();
        a_in_data = 16'h0032; qa.push_back(16'h0032);
        step();
        a_flush = 1'b1; a_in_data = 16'h000C;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        qa.delete();
        check_output("t3_count", {30'b0, a_count}, 32'd0);
        check_output("t3_out_valid", {31'b0, a_out_valid}, 32'd0);
        check_output("t3_out_data", {16'b0, a_out_data}, {16'b0, BUB});
        check_output("t3_in_ready", {31'b0, a_in_ready}, 32'd1);
        a_out_ready = 1'b1;
        step(); step();

        // Simultaneous in/out fire with one entry held
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 16'h0005; qa.push_back(16'h0005);
        step();
        a_in_data = 16'h0006; a_out_ready = 1'b1; qa.push_back(16'h0006);
        step();
        check_output("t4_count", {30'b0, a_count}, 32'd1);
        check_output("t4_out_data", {16'b0, a_out_data}, 32'h0006);
        a_in_valid = 1'b0;
        step();
        check_output("t4_end_count", {30'b0, a_count}, 32'd0);

        // Async reset between clock edges while full
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 16'h0051; qa.push_back(16'h0051);
        step();
        a_in_data = 16'h0052; qa.push_back(16'h0052);
        step();
        a_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_output("t5_out_valid", {31'b0, a_out_valid}, 32'd0);
        check_output("t5_count", {30'b0, a_count}, 32'd0);
        check_output("t5_in_ready", {31'b0, a_in_ready}, 32'd1);
        check_output("t5_out_data", {16'b0, a_out_data}, {16'b0, BUB});
        qa.delete();
        step(); step();
        rst = 1'b0;
        a_in_valid = 1'b1; a_in_data = 16'h0099; a_out_ready = 1'b1; qa.push_back(16'h0099);
        step();
        check_output("t5_post_valid", {31'b0, a_out_valid}, 32'd1);
        a_in_valid = 1'b0;
        step();
        check_output("t5_post_empty", {31'b0, a_out_valid}, 32'd0);

        // Single-entry build: in_ready looks through to out_ready
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 16'h0061; qb.push_back(16'h0061);
        step();
        b_in_valid = 1'b0;
        check_output("t6_count", {30'b0, b_count}, 32'd1);
        check_output("t6_in_ready_stall", {31'b0, b_in_ready}, 32'd0);
        b_out_ready = 1'b1;
        #1;
        check_output("t6_in_ready_comb", {31'b0, b_in_ready}, 32'd1);
        for (int v = 16'h62; v <= 16'h65; v++) begin
          b_in_valid = 1'b1;
          b_in_data  = 16'(v);
          qb.push_back(16'(v));
          step();
          check_output("t6_stream_count", {30'b0, b_count}, 32'd1);
          check_output("t6_stream_ready", {31'b0, b_in_ready}, 32'd1);
        end
        b_in_valid = 1'b0;
        step();
        check_output("t6_end_count", {30'b0, b_count}, 32'd0);
        check_output("t6_end_data", {16'b0, b_out_data}, {16'b0, BUB});
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (!done && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
              tests++; fails++;
              $display("[TB] FAIL skid_unexpected: got %h expected no output", a_out_data);
            end else begin
              check_output("skid_payload", {16'b0, a_out_data}, {16'b0, qa.pop_front()});
            end
          end
          if (!done && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
              tests++; fails++;
              $display("[TB] FAIL single_unexpected: got %h expected no output", b_out_data);
            end else begin
              check_output("single_payload", {16'b0, b_out_data}, {16'b0, qb.pop_front()});
            end
          end
        end
      end
    join
    check_output("skid_drained", 32'(qa.size()), 32'd0);
    check_output("single_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
